mem_arbiter: RTL and testbench

Two-requester arbiter that shares the core's single-port unified memory between the instruction-fetch stage and the data-access stage. It issues one memory command per cycle and returns read data one cycle later to the requester that owned the command. Fixed priority favours data accesses, with a starvation limit that guarantees fetch progress. An optional check rejects misaligned fetches without touching memory.

---
 rtl/mem_arbiter_if.sv | 64 ++++++
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//
// Bundles the arbiter's bus signals: the instruction-fetch requester port
// (if_*), the data-access requester port (d_*) and the single-port memory
// command/response port (m_*).
//
// Modports
//   slave  : arbiter view. Requests, request payloads and m_rdata are inputs.
//            Grants, responses and the memory command are outputs.
//   master : environment view (requesters plus memory). Directions are the
//            mirror image of slave.
//
// Parameter
//   ADDR_W : byte-address width of both requester ports. m_addr is a word
//            address, so it is ADDR_W-2 bits wide.
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int ADDR_W = 16
);
  // Instruction-fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              if_fault;

  // Data-access port
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;

  // Memory port
  logic              m_en;
  logic              m_we;
  logic [3:0]        m_be;
  logic [ADDR_W-3:0] m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_fault,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_be, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_fault,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_be, m_addr, m_wdata,
    output m_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port unified memory between the instruction-fetch stage
// and the data-access stage. One memory command is issued per cycle; read
// data comes back one cycle later and is steered to whichever requester
// owned the command.
//
// Arbitration: data accesses have fixed priority, except that after
// STARVE_MAX consecutive data grants with a fetch waiting, the fetch wins
// one cycle. With both requesters saturating the pattern is STARVE_MAX data
// grants followed by one fetch grant.
//
// Parameters
//   ADDR_W     : byte-address width of both requester ports (default 16).
//   STARVE_MAX : max consecutive data grants while a fetch waits, 1..15.
//
// Ports
//   clk : clock, rising edge.
//   rst : asynchronous active-low reset. Clears the response owner and the
//         starvation counter, drops any in-flight response and holds both
//         grants (and therefore the memory command) low.
//   bus : mem_arbiter_if.slave
//         if_req/if_addr           -> fetch request (held until if_gnt)
//         if_gnt                   <- fetch accepted (combinational)
//         if_rvalid/if_rdata/if_fault <- fetch response, one cycle after grant
//         d_req/d_we/d_be/d_addr/d_wdata -> data request (held until d_gnt)
//         d_gnt                    <- data accepted (combinational)
//         d_rvalid/d_rdata         <- data read response, one cycle after grant
//         m_en/m_we/m_be/m_addr/m_wdata <- memory command
//         m_rdata                  -> memory read data, cycle after m_en read
//
// Build option
//   MEM_ARBITER_MISALIGN_CHECK_EN : when defined, a winning fetch whose
//   if_addr[1:0] is non-zero is granted but issues no memory command; its
//   response is a fault (if_rvalid=1, if_fault=1, if_rdata=0). When not
//   defined, if_addr[1:0] is ignored and if_fault is always 0.
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  // Who the response in the following cycle belongs to. Data writes produce
  // no response, so they record OWN_NONE just like an idle cycle.
  typedef enum logic [1:0] {
    OWN_NONE    = 2'd0,
    OWN_FETCH   = 2'd1,
    OWN_DATA_RD = 2'd2,
    OWN_FAULT   = 2'd3
  } owner_t;

  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  owner_t     owner_reg;
  owner_t     owner_next;
  logic [3:0] starve_cnt_reg;
  logic [3:0] starve_cnt_next;

  logic       d_win;
  logic       f_win;
  logic       fetch_fault;
  logic       starve_hit;

  // -------------------------------------------------------------------------
  // Misaligned-fetch detection (build option)
  // -------------------------------------------------------------------------
`ifdef MEM_ARBITER_MISALIGN_CHECK_EN
  assign fetch_fault = (bus.if_addr[1:0] != 2'b00);
`else
  assign fetch_fault = 1'b0;
`endif

  // A waiting fetch that has been passed over STARVE_MAX times takes the slot.
  assign starve_hit = bus.if_req && (starve_cnt_reg == STARVE_LIMIT);

  // -------------------------------------------------------------------------
  // Selection. Grants are combinational from the current requests so a
  // selected requester is accepted in the same cycle; reset masks both.
  // -------------------------------------------------------------------------
  always_comb begin
    d_win = 1'b0;
    f_win = 1'b0;
    if (rst) begin
      d_win = bus.d_req && !starve_hit;
      f_win = bus.if_req && !d_win;
    end
  end

  // -------------------------------------------------------------------------
  // State register: response owner and starvation counter.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_reg      <= OWN_NONE;
      starve_cnt_reg <= 4'd0;
    end else begin
      owner_reg      <= owner_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic.
  // -------------------------------------------------------------------------
  always_comb begin
    owner_next      = OWN_NONE;
    starve_cnt_next = starve_cnt_reg;

    if (d_win) begin
      owner_next = bus.d_we ? OWN_NONE : OWN_DATA_RD;
    end else if (f_win) begin
      owner_next = fetch_fault ? OWN_FAULT : OWN_FETCH;
    end

    // The counter only measures how long a fetch has been waiting: it is
    // meaningless (and cleared) whenever no fetch is pending, and a fetch
    // grant, faulting or not, ends the wait.
    if (!bus.if_req) begin
      starve_cnt_next = 4'd0;
    end else if (f_win) begin
      starve_cnt_next = 4'd0;
    end else if (d_win && (starve_cnt_reg != STARVE_LIMIT)) begin
      starve_cnt_next = starve_cnt_reg + 4'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Output logic: grants, memory command and response steering.
  // -------------------------------------------------------------------------
  always_comb begin
    bus.d_gnt     = d_win;
    bus.if_gnt    = f_win;

    // Idle cycles and faulting fetches drive an all-zero command.
    bus.m_en      = 1'b0;
    bus.m_we      = 1'b0;
    bus.m_be      = 4'b0000;
    bus.m_addr    = '0;
    bus.m_wdata   = 32'd0;

    if (d_win) begin
      bus.m_en    = 1'b1;
      bus.m_we    = bus.d_we;
      // Reads always fetch the whole word regardless of d_be.
      bus.m_be    = bus.d_we ? bus.d_be : 4'b1111;
      bus.m_addr  = bus.d_addr[ADDR_W-1:2];
      bus.m_wdata = bus.d_wdata;
    end else if (f_win && !fetch_fault) begin
      bus.m_en    = 1'b1;
      bus.m_we    = 1'b0;
      bus.m_be    = 4'b1111;
      bus.m_addr  = bus.if_addr[ADDR_W-1:2];
      bus.m_wdata = 32'd0;
    end

    // The response follows the registered owner; m_rdata is the memory's
    // answer to last cycle's command. Unselected rdata outputs read zero.
    bus.if_rvalid = 1'b0;
    bus.if_fault  = 1'b0;
    bus.if_rdata  = 32'd0;
    bus.d_rvalid  = 1'b0;
    bus.d_rdata   = 32'd0;

    case (owner_reg)
      OWN_FETCH: begin
        bus.if_rvalid = 1'b1;
        bus.if_rdata  = bus.m_rdata;
      end
      OWN_DATA_RD: begin
        bus.d_rvalid  = 1'b1;
        bus.d_rdata   = bus.m_rdata;
      end
      OWN_FAULT: begin
        bus.if_rvalid = 1'b1;
        bus.if_fault  = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Drives mem_arbiter with directed sequences (reset, aligned/misaligned
// fetch, contention pattern, write-then-read, reset during a read) followed
// by a randomized phase. A behavioural model of the arbitration rules and
// the memory contents is evaluated on every falling edge and compared with
// the DUT outputs. The directed sequences also compare against literal
// values to pin the model.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int ADDR_W     = 16;
  localparam int STARVE_MAX = 4;
  localparam int WORDS      = 1 << (ADDR_W - 2);

`ifdef MEM_ARBITER_MISALIGN_CHECK_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  logic clk;
  logic rst;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(
    .ADDR_W     (ADDR_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] w;
    w = (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    if (i == 32'h11) w = 32'hCAFE_0011;
    if (i == 32'h40) w = 32'h1234_5678;
    return w;
  endfunction

  // -------------------------------------------------------------------------
  // Memory seen by the DUT: write-first, one-cycle read latency. Idle cycles
  // return junk so that leaking m_rdata to a response output is visible.
  // -------------------------------------------------------------------------
  logic [31:0] mem [0:WORDS-1];
  logic [31:0] ref_mem [0:WORDS-1];

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      mem[i]     = init_word(i);
      ref_mem[i] = init_word(i);
    end
    bus.m_rdata = 32'd0;
  end

  always @(posedge clk) begin
    if (bus.m_en && bus.m_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.m_be[b]) mem[bus.m_addr][8*b +: 8] <= bus.m_wdata[8*b +: 8];
      end
      bus.m_rdata <= $urandom();
    end else if (bus.m_en) begin
      bus.m_rdata <= mem[bus.m_addr];
    end else begin
      bus.m_rdata <= $urandom();
    end
  end

  // -------------------------------------------------------------------------
  // Reference model + per-cycle compare. Inputs only change just after a
  // rising edge, so at the falling edge they equal what the next rising
  // edge samples.
  //   exp_kind: 0 none, 1 fetch data, 2 data read, 3 fetch fault
  //   waits   : data grants handed out while the current fetch waits
  // -------------------------------------------------------------------------
  int          exp_kind = 0;
  logic [31:0] exp_data = 32'd0;
  int          waits = 0;
  bit          pend_w = 1'b0;
  int          pend_idx = 0;
  logic [3:0]  pend_be = 4'd0;
  logic [31:0] pend_data = 32'd0;

  always @(negedge clk) begin : model
    bit          d_w, f_w, flt;
    bit          e_en, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata;
    int          widx, fidx;

    // A write issued last cycle has been committed by the rising edge.
    if (pend_w) begin
      for (int b = 0; b < 4; b++)
        if (pend_be[b]) ref_mem[pend_idx][8*b +: 8] = pend_data[8*b +: 8];
      pend_w = 1'b0;
    end

    if (!rst) begin
      check("reset if_gnt",    32'(bus.if_gnt),    32'd0);
      check("reset d_gnt",     32'(bus.d_gnt),     32'd0);
      check("reset m_en",      32'(bus.m_en),      32'd0);
      check("reset m_addr",    32'(bus.m_addr),    32'd0);
      check("reset if_rvalid", 32'(bus.if_rvalid), 32'd0);
      check("reset if_rdata",  bus.if_rdata,       32'd0);
      check("reset if_fault",  32'(bus.if_fault),  32'd0);
      check("reset d_rvalid",  32'(bus.d_rvalid),  32'd0);
      check("reset d_rdata",   bus.d_rdata,        32'd0);
      exp_kind = 0;
      waits    = 0;
    end else begin
      // Response to last cycle's grant
      check("if_rvalid", 32'(bus.if_rvalid), 32'((exp_kind == 1) || (exp_kind == 3)));
      check("if_fault",  32'(bus.if_fault),  32'(exp_kind == 3));
      check("if_rdata",  bus.if_rdata,       (exp_kind == 1) ? exp_data : 32'd0);
      check("d_rvalid",  32'(bus.d_rvalid),  32'(exp_kind == 2));
      check("d_rdata",   bus.d_rdata,        (exp_kind == 2) ? exp_data : 32'd0);

      // Arbitration for this cycle
      d_w = bus.d_req && !(bus.if_req && (waits >= STARVE_MAX));
      f_w = !d_w && bus.if_req;
      flt = f_w && MISALIGN_EN && (bus.if_addr[1:0] != 2'b00);
      widx = int'(bus.d_addr) / 4;
      fidx = int'(bus.if_addr) / 4;

      e_en = 1'b0; e_we = 1'b0; e_be = 4'd0; e_addr = 32'd0; e_wdata = 32'd0;
      if (d_w) begin
        e_en = 1'b1; e_we = bus.d_we; e_be = bus.d_we ? bus.d_be : 4'hF;
        e_addr = 32'(widx); e_wdata = bus.d_wdata;
      end else if (f_w && !flt) begin
        e_en = 1'b1; e_be = 4'hF; e_addr = 32'(fidx);
      end

      check("d_gnt",   32'(bus.d_gnt),  32'(d_w));
      check("if_gnt",  32'(bus.if_gnt), 32'(f_w));
      check("m_en",    32'(bus.m_en),   32'(e_en));
      check("m_we",    32'(bus.m_we),   32'(e_we));
      check("m_be",    32'(bus.m_be),   32'(e_be));
      check("m_addr",  32'(bus.m_addr), e_addr);
      check("m_wdata", bus.m_wdata,     e_wdata);

      exp_kind = 0;
      exp_data = 32'd0;
      if (d_w && bus.d_we) begin
        pend_w = 1'b1; pend_idx = widx; pend_be = bus.d_be; pend_data = bus.d_wdata;
      end else if (d_w) begin
        exp_kind = 2; exp_data = ref_mem[widx];
      end else if (flt) begin
        exp_kind = 3;
      end else if (f_w) begin
        exp_kind = 1; exp_data = ref_mem[fidx];
      end

      if (!bus.if_req || f_w) waits = 0;
      else if (d_w && waits < STARVE_MAX) waits++;
    end
  end

  // -------------------------------------------------------------------------
  // Directed helpers
  // -------------------------------------------------------------------------
  task automatic wait_gnt(input bit is_fetch, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); #1;
      if (is_fetch ? bus.if_gnt : bus.d_gnt) ok = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic contention(input string tag);
    logic [9:0] seq;
    int         bad;
    seq = '0;
    bad = 0;
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 16'h0080;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 16'h0010; bus.d_wdata = 32'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      seq[i] = bus.if_gnt;
      if (bus.if_gnt == bus.d_gnt) bad++;
      @(posedge clk); #1;
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    $display("%s: contention grants (1=fetch, first at bit 0) = %b", tag, seq);
    check({tag, " grant sequence"}, 32'(seq), 32'h210);
    check({tag, " exactly one grant"}, 32'(bad), 32'd0);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin : drive
    bit ok, fg, dg;
    int n_f, n_d;

    rst = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 16'h0000;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'h0; bus.d_addr = 16'h0000; bus.d_wdata = 32'd0;

    // Reset with both requests high: no grants, no command
    repeat (3) @(negedge clk);
    #1;
    check("rst both gnt", 32'({bus.if_gnt, bus.d_gnt}), 32'd0);
    check("rst m_en", 32'(bus.m_en), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.if_req = 1'b0; bus.d_req = 1'b0;

    // Aligned fetch of 0x0044
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 16'h0044;
    wait_gnt(1'b1, ok);
    check("fetch44 granted", 32'(ok), 32'd1);
    check("fetch44 m_addr", 32'(bus.m_addr), 32'h11);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    @(negedge clk); #1;
    check("fetch44 if_rvalid", 32'(bus.if_rvalid), 32'd1);
    check("fetch44 if_rdata", bus.if_rdata, 32'hCAFE_0011);
    $display("fetch addr=0x0044 rvalid=%0d rdata=0x%08h", bus.if_rvalid, bus.if_rdata);

    contention("after reset release");

    // Write-then-read back to back
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011;
    bus.d_addr = 16'h0100; bus.d_wdata = 32'hDEAD_BEEF;
    wait_gnt(1'b0, ok);
    check("write granted", 32'(ok), 32'd1);
    check("write m_be", 32'(bus.m_be), 32'h3);
    @(posedge clk); #1;
    bus.d_we = 1'b0; bus.d_be = 4'b0000; bus.d_wdata = 32'd0;
    wait_gnt(1'b0, ok);
    check("read granted", 32'(ok), 32'd1);
    check("read m_be forced", 32'(bus.m_be), 32'hF);
    check("write gives no d_rvalid", 32'(bus.d_rvalid), 32'd0);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    @(negedge clk); #1;
    check("rd-after-wr d_rvalid", 32'(bus.d_rvalid), 32'd1);
    check("rd-after-wr d_rdata", bus.d_rdata, 32'h1234_BEEF);
    check("rd-after-wr no if_rvalid", 32'(bus.if_rvalid), 32'd0);
    $display("data write/read addr=0x0100 rdata=0x%08h", bus.d_rdata);

    // Misaligned fetch of 0x0046
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 16'h0046;
    wait_gnt(1'b1, ok);
    check("fetch46 granted", 32'(ok), 32'd1);
`ifdef MEM_ARBITER_MISALIGN_CHECK_EN
    check("fetch46 m_en", 32'(bus.m_en), 32'd0);
`else
    check("fetch46 m_addr", 32'(bus.m_addr), 32'h11);
`endif
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    @(negedge clk); #1;
    check("fetch46 if_rvalid", 32'(bus.if_rvalid), 32'd1);
`ifdef MEM_ARBITER_MISALIGN_CHECK_EN
    check("fetch46 if_fault", 32'(bus.if_fault), 32'd1);
    check("fetch46 if_rdata", bus.if_rdata, 32'd0);
`else
    check("fetch46 if_fault", 32'(bus.if_fault), 32'd0);
    check("fetch46 if_rdata", bus.if_rdata, 32'hCAFE_0011);
`endif
    $display("fetch addr=0x0046 fault=%0d rdata=0x%08h", bus.if_fault, bus.if_rdata);

    // Reset while a data read is granted but before its edge
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 16'h0104;
    wait_gnt(1'b0, ok);
    check("midreset read granted", 32'(ok), 32'd1);
    rst = 1'b0;
    bus.d_req = 1'b0;
    @(negedge clk); #1;
    check("midreset d_rvalid", 32'(bus.d_rvalid), 32'd0);
    check("midreset d_rdata", bus.d_rdata, 32'd0);
    $display("data read addr=0x0104 discarded by reset, d_rvalid=%0d", bus.d_rvalid);
    @(posedge clk); #1;
    rst = 1'b1;
    contention("after mid-op reset");

    // Randomized phase: requesters obey hold-until-grant, occasional resets
    n_f = 0;
    n_d = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); #1;
      fg = bus.if_gnt;
      dg = bus.d_gnt;
      if (fg) n_f++;
      if (dg) n_d++;
      @(posedge clk); #1;
      if (fg) bus.if_req = 1'b0;
      if (dg) bus.d_req = 1'b0;
      if (!rst) begin
        rst = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        rst = 1'b0;
        bus.if_req = 1'b0;
        bus.d_req = 1'b0;
      end
      if (!bus.if_req && $urandom_range(0, 3) != 0) begin
        bus.if_req  = 1'b1;
        bus.if_addr = {8'd0, 6'($urandom_range(0, 63)),
                       ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00};
      end
      if (!bus.d_req && $urandom_range(0, 2) != 0) begin
        bus.d_req   = 1'b1;
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_be    = 4'($urandom_range(0, 15));
        bus.d_addr  = {8'd0, 6'($urandom_range(0, 63)), 2'b00};
        bus.d_wdata = $urandom();
      end
    end
    $display("random phase: %0d fetch grants, %0d data grants", n_f, n_d);
    check("random phase made fetch progress", 32'(n_f > 100), 32'd1);

    @(posedge clk); #1;
    bus.if_req = 1'b0;
    bus.d_req = 1'b0;
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "timeout");
  end

endmodule
